dcache_tag_ctrl: RTL and testbench
==================================

// Module: dcache_tag_ctrl
// PURPOSE
//  Initiator/controller side of the data cache tag store SRAM.
//  - Owns every tag store access: post-reset/flush invalidation sweep, per-request tag lookup
//    and compare, dirty-bit set on store hits, and tag install on refill.
//  - Sits between the dcache request path and the tag store; reports hit/miss and victim info
//    to the miss handler.
// PARAMETERS
//  NUM_WORDS  256  number of cache indexes (power of 2)
//  TAG_WIDTH  20   address tag width; store word = TAG_WIDTH+2 bits
// PORTS
//  clk_i               in   1          system clock
//  rst_ni              in   1          asynchronous active-low reset
//  req_valid_i         in   1          lookup request
//  req_ready_o         out  1          request accepted when valid&ready
//  req_index_i         in   log2(NW)   cache index
//  req_tag_i           in   TAG_WIDTH  address tag
//  req_we_i            in   1          1=store (sets dirty), 0=load
//  resp_valid_o        out  1          one-cycle pulse, lookup result
//  resp_hit_o          out  1          tag match with valid=1
//  resp_victim_valid_o out  1          missed line held valid data
//  resp_victim_dirty_o out  1          missed line dirty (writeback needed)
//  resp_victim_tag_o   out  TAG_WIDTH  tag of missed line
//  refill_valid_i      in   1          miss handler done; install pending tag
//  flush_i             in   1          invalidate whole cache (pulse)
//  init_done_o         out  1          one-cycle pulse, sweep finished
//  ts_en_o             out  1          tag store enable
//  ts_we_o             out  1          tag store write enable
//  ts_addr_o           out  log2(NW)   tag store index
//  ts_wdata_o          out  TAG_WIDTH+2  {valid,dirty,tag}
//  ts_bit_en_o         out  TAG_WIDTH+2  per-bit write enable
//  ts_rdata_i          in   TAG_WIDTH+2  read data; address latched on negedge, valid 2nd half-cycle
// BEHAVIOUR
//  - Word layout: [TAG_WIDTH+1]=valid, [TAG_WIDTH]=dirty, [TAG_WIDTH-1:0]=tag.
//  - Reset: state=INIT, sweep counter=0.
//    All resp_*, init_done_o, req_ready_o and ts_we_o = 0.
//  - States: INIT, IDLE, MISS.
//  - INIT: one write per cycle, counter 0..NUM_WORDS-1.
//    - Drives ts_en=ts_we=1, wdata=0, bit_en=all ones.
//    - Last index: init_done_o pulses the same cycle, next state IDLE.
//    - Sweep takes exactly NUM_WORDS cycles; req_ready_o=0 throughout.
//  - IDLE: req_ready_o = !flush_i.
//    - flush_i has priority over req_valid_i: counter=0, next state INIT.
//  - Lookup accepted in cycle N: ts_en=1, ts_addr=req_index_i in N.
//    - Compare ts_rdata_i with req_tag_i combinationally in N; hit = valid & tag equal.
//    - Store hit with dirty=0: ts_we=1 in N (posedge write), bit_en=dirty bit only,
//      wdata dirty=1. Load hit, or store hit already dirty: no write.
//    - Registered at end of N: resp_valid_o=1 in N+1 with hit and victim fields.
//      Victim fields are the raw read word, valid only on miss; zero on hit.
//    - Hit: stay IDLE; back-to-back requests give 1 resp per cycle.
//    - Miss: latch index, tag and we; next state MISS.
//  - MISS: req_ready_o=0; flush_i is ignored (held off).
//    - Wait for refill_valid_i. In that cycle: ts_en=ts_we=1, addr=latched index,
//      wdata={1,latched we,latched tag}, bit_en=all ones. Next state IDLE.
//    - refill_valid_i in INIT or IDLE is ignored.
//  - ts_en_o=0 whenever no access is issued; ts_we_o never 1 without ts_en_o.
//  - Async reset mid-operation: pending miss dropped, sweep restarts from 0.
// TESTING
//  - Reset release -> 256 consecutive writes, idx 0..255, wdata=0;
//    init_done_o pulses on idx 255; req_ready_o rises next cycle.
//  - Load idx 5, tag 0x12345 after init -> resp hit=0, victim_valid=0;
//    refill -> write {1,0,0x12345} @5; repeat load -> hit=1, no ts write.
//  - Store hit on clean line idx 5 -> ts_we in accept cycle, bit_en=only bit 20, wdata bit 20=1;
//    next store -> no write.
//  - Load idx 5 tag 0x00001 (line dirty, tag 0x12345) -> hit=0, victim_valid=1,
//    victim_dirty=1, victim_tag=0x12345.
//  - flush_i and req_valid_i same IDLE cycle -> req not accepted, full sweep; flush_i in MISS ignored.
//  - rst_ni low during MISS, then refill_valid_i after release -> no install; sweep from idx 0.

Source files
------------

// File: rtl/dcache_tag_ctrl.sv
// Data cache tag store controller: init/flush sweep, lookup+compare, dirty set on store hit, refill install.
// Lookup result one cycle after accept; no requests accepted during sweep, flush or outstanding miss.
module dcache_tag_ctrl #(
  parameter int NUM_WORDS = 256,
  parameter int TAG_WIDTH = 20,
  localparam int IW = $clog2(NUM_WORDS),
  localparam int WW = TAG_WIDTH + 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IW-1:0]        req_index_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  input  logic                 req_we_i,
  output logic                 resp_valid_o,
  output logic                 resp_hit_o,
  output logic                 resp_victim_valid_o,
  output logic                 resp_victim_dirty_o,
  output logic [TAG_WIDTH-1:0] resp_victim_tag_o,
  input  logic                 refill_valid_i,
  input  logic                 flush_i,
  output logic                 init_done_o,
  output logic                 ts_en_o,
  output logic                 ts_we_o,
  output logic [IW-1:0]        ts_addr_o,
  output logic [WW-1:0]        ts_wdata_o,
  output logic [WW-1:0]        ts_bit_en_o,
  input  logic [WW-1:0]        ts_rdata_i
);

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] tag;
  } tag_word_t;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    MISS = 2'd2
  } state_t;

  localparam logic [WW-1:0] DIRTY_BIT_EN = WW'(1) << TAG_WIDTH;
  localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_WORDS - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        miss_index_q;
  logic [TAG_WIDTH-1:0] miss_tag_q;
  logic                 miss_we_q;

  tag_word_t            rd_word;
  tag_word_t            wr_word;
  logic                 lookup_hit;
  logic                 accept;

  assign rd_word    = tag_word_t'(ts_rdata_i);
  assign lookup_hit = rd_word.valid && (rd_word.tag == req_tag_i);
  assign ts_wdata_o = wr_word;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_o = 1'b0;
    init_done_o = 1'b0;
    accept      = 1'b0;
    ts_en_o     = 1'b0;
    ts_we_o     = 1'b0;
    ts_addr_o   = '0;
    wr_word     = '0;
    ts_bit_en_o = '0;

    unique case (state_q)
      INIT: begin
        // Held quiet while reset is asserted; the sweep starts the cycle reset releases.
        if (rst_ni) begin
          ts_en_o     = 1'b1;
          ts_we_o     = 1'b1;
          ts_addr_o   = cnt_q;
          ts_bit_en_o = '1;
          if (cnt_q == LAST_IDX) begin
            init_done_o = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end

      IDLE: begin
        if (flush_i) begin
          cnt_d   = '0;
          state_d = INIT;
        end else begin
          req_ready_o = 1'b1;
          if (req_valid_i) begin
            accept    = 1'b1;
            ts_en_o   = 1'b1;
            ts_addr_o = req_index_i;
            // Dirty set rides on the read cycle; the SRAM writes at the closing posedge.
            if (lookup_hit && req_we_i && !rd_word.dirty) begin
              ts_we_o       = 1'b1;
              ts_bit_en_o   = DIRTY_BIT_EN;
              wr_word       = rd_word;
              wr_word.dirty = 1'b1;
            end
            if (!lookup_hit) begin
              state_d = MISS;
            end
          end
        end
      end

      MISS: begin
        if (refill_valid_i) begin
          ts_en_o       = 1'b1;
          ts_we_o       = 1'b1;
          ts_addr_o     = miss_index_q;
          ts_bit_en_o   = '1;
          wr_word.valid = 1'b1;
          wr_word.dirty = miss_we_q;
          wr_word.tag   = miss_tag_q;
          state_d       = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q             <= INIT;
      cnt_q               <= '0;
      miss_index_q        <= '0;
      miss_tag_q          <= '0;
      miss_we_q           <= 1'b0;
      resp_valid_o        <= 1'b0;
      resp_hit_o          <= 1'b0;
      resp_victim_valid_o <= 1'b0;
      resp_victim_dirty_o <= 1'b0;
      resp_victim_tag_o   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_o <= accept;
      resp_hit_o   <= accept && lookup_hit;
      if (accept && !lookup_hit) begin
        miss_index_q        <= req_index_i;
        miss_tag_q          <= req_tag_i;
        miss_we_q           <= req_we_i;
        resp_victim_valid_o <= rd_word.valid;
        resp_victim_dirty_o <= rd_word.dirty;
        resp_victim_tag_o   <= rd_word.tag;
      end else begin
        resp_victim_valid_o <= 1'b0;
        resp_victim_dirty_o <= 1'b0;
        resp_victim_tag_o   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Directed bench for dcache_tag_ctrl with a behavioural tag store (negedge read, posedge bit-masked write).
module tb_dcache_tag_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_index;
  logic [19:0] req_tag;
  logic        req_we;
  logic        resp_valid;
  logic        resp_hit;
  logic        resp_victim_valid;
  logic        resp_victim_dirty;
  logic [19:0] resp_victim_tag;
  logic        refill_valid;
  logic        flush;
  logic        init_done;
  logic        ts_en;
  logic        ts_we;
  logic [7:0]  ts_addr;
  logic [21:0] ts_wdata;
  logic [21:0] ts_bit_en;
  logic [21:0] ts_rdata;

  logic [21:0] mem [256];
  int n_cmp;
  int n_err;

  dcache_tag_ctrl #(.NUM_WORDS(256), .TAG_WIDTH(20)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_index_i         (req_index),
    .req_tag_i           (req_tag),
    .req_we_i            (req_we),
    .resp_valid_o        (resp_valid),
    .resp_hit_o          (resp_hit),
    .resp_victim_valid_o (resp_victim_valid),
    .resp_victim_dirty_o (resp_victim_dirty),
    .resp_victim_tag_o   (resp_victim_tag),
    .refill_valid_i      (refill_valid),
    .flush_i             (flush),
    .init_done_o         (init_done),
    .ts_en_o             (ts_en),
    .ts_we_o             (ts_we),
    .ts_addr_o           (ts_addr),
    .ts_wdata_o          (ts_wdata),
    .ts_bit_en_o         (ts_bit_en),
    .ts_rdata_i          (ts_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag store model
  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 22'h3FFFFF;
    ts_rdata = 22'h3FFFFF;
  end
  always @(negedge clk) if (ts_en) ts_rdata = mem[ts_addr];
  always @(posedge clk) if (ts_en && ts_we)
    mem[ts_addr] = (mem[ts_addr] & ~ts_bit_en) | (ts_wdata & ts_bit_en);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1 of sweep cycle 'start'; ends at posedge+1 of the cycle after the sweep.
  task automatic sweep_check(input string name, input int start);
    int nz;
    for (int i = start; i < 256; i++) begin
      #7;
      n_cmp++;
      if ({ts_en, ts_we, ts_addr, ts_wdata, ts_bit_en, init_done, req_ready} !==
          {1'b1, 1'b1, 8'(i), 22'h0, 22'h3FFFFF, (i == 255), 1'b0}) begin
        n_err++;
        $display("FAIL %s idx %0d: en=%b we=%b addr=%0d wdata=%h bit_en=%h done=%b rdy=%b, want 1 1 %0d 0 3fffff %b 0",
                 name, i, ts_en, ts_we, ts_addr, ts_wdata, ts_bit_en, init_done, req_ready, i, (i == 255));
      end
      next_cycle();
    end
    #7;
    n_cmp++;
    if ({req_ready, ts_en, init_done} !== 3'b100) begin
      n_err++;
      $display("FAIL %s post-sweep: ready/en/done=%b want 100", name, {req_ready, ts_en, init_done});
    end
    nz = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== 22'h0) nz++;
    n_cmp++;
    if (nz != 0) begin
      n_err++;
      $display("FAIL %s store_clear: %0d nonzero words, want 0", name, nz);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_index = '0; req_tag = '0; req_we = 1'b0;
    refill_valid = 1'b0; flush = 1'b0;
    next_cycle();
    #7;
    n_cmp++;
    if ({ts_en, ts_we, init_done, req_ready, resp_valid, resp_hit, resp_victim_valid} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_state: en/we/done/rdy/rv/hit/vv=%b want 0000000",
               {ts_en, ts_we, init_done, req_ready, resp_valid, resp_hit, resp_victim_valid});
    end
    next_cycle();
    rst_n = 1'b1;
    sweep_check("init_sweep", 0);
  endtask

  task automatic test_miss_refill();
    req_valid = 1'b1; req_index = 8'd5; req_tag = 20'h12345; req_we = 1'b0;
    #7;
    n_cmp++;
    if ({req_ready, ts_en, ts_we, ts_addr} !== {3'b110, 8'd5}) begin
      n_err++;
      $display("FAIL load_accept: rdy/en/we=%b addr=%0d want 110 5", {req_ready, ts_en, ts_we}, ts_addr);
    end
    next_cycle();
    req_valid = 1'b0;
    #7;
    n_cmp++;
    if ({resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty, resp_victim_tag} !== {4'b1000, 20'h0}) begin
      n_err++;
      $display("FAIL cold_miss_resp: v/hit/vv/vd=%b vtag=%h want 1000 0",
               {resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty}, resp_victim_tag);
    end
    n_cmp++;
    if ({req_ready, ts_en} !== 2'b00) begin
      n_err++;
      $display("FAIL miss_wait: rdy/en=%b want 00", {req_ready, ts_en});
    end
    next_cycle();
    refill_valid = 1'b1;
    #7;
    n_cmp++;
    if ({ts_en, ts_we, ts_addr, ts_wdata, ts_bit_en, resp_valid} !== {2'b11, 8'd5, 22'h212345, 22'h3FFFFF, 1'b0}) begin
      n_err++;
      $display("FAIL refill_write: en/we=%b addr=%0d wdata=%h bit_en=%h rv=%b want 11 5 212345 3fffff 0",
               {ts_en, ts_we}, ts_addr, ts_wdata, ts_bit_en, resp_valid);
    end
    next_cycle();
    refill_valid = 1'b0;
    req_valid = 1'b1;
    #7;
    n_cmp++;
    if ({req_ready, ts_en, ts_we} !== 3'b110) begin
      n_err++;
      $display("FAIL load_hit_nowrite: rdy/en/we=%b want 110", {req_ready, ts_en, ts_we});
    end
    next_cycle();
    req_valid = 1'b0;
    #7;
    n_cmp++;
    if ({resp_valid, resp_hit, resp_victim_valid, resp_victim_tag} !== {3'b110, 20'h0}) begin
      n_err++;
      $display("FAIL load_hit_resp: v/hit/vv=%b vtag=%h want 110 0", {resp_valid, resp_hit, resp_victim_valid}, resp_victim_tag);
    end
    next_cycle();
  endtask

  task automatic test_store_dirty();
    req_valid = 1'b1; req_index = 8'd5; req_tag = 20'h12345; req_we = 1'b1;
    #7;
    n_cmp++;
    if ({ts_en, ts_we, ts_bit_en, ts_wdata[20]} !== {2'b11, 22'h100000, 1'b1}) begin
      n_err++;
      $display("FAIL store_clean_write: en/we=%b bit_en=%h dirty=%b want 11 100000 1",
               {ts_en, ts_we}, ts_bit_en, ts_wdata[20]);
    end
    next_cycle();
    #7;
    n_cmp++;
    if ({ts_en, ts_we, resp_valid, resp_hit} !== 4'b1011) begin
      n_err++;
      $display("FAIL store_dirty_nowrite: en/we/rv/hit=%b want 1011", {ts_en, ts_we, resp_valid, resp_hit});
    end
    n_cmp++;
    if (mem[5] !== 22'h312345) begin
      n_err++;
      $display("FAIL store_mem_word: got %h want 312345", mem[5]);
    end
    next_cycle();
    req_valid = 1'b0; req_we = 1'b0;
    #7;
    n_cmp++;
    if ({resp_valid, resp_hit, req_ready} !== 3'b111) begin
      n_err++;
      $display("FAIL store2_resp: rv/hit/rdy=%b want 111", {resp_valid, resp_hit, req_ready});
    end
    next_cycle();
  endtask

  task automatic test_victim_and_miss_flush();
    req_valid = 1'b1; req_index = 8'd5; req_tag = 20'h00001; req_we = 1'b0;
    #7;
    n_cmp++;
    if ({ts_en, ts_we} !== 2'b10) begin
      n_err++;
      $display("FAIL conflict_accept: en/we=%b want 10", {ts_en, ts_we});
    end
    next_cycle();
    req_valid = 1'b0;
    flush = 1'b1;
    #7;
    n_cmp++;
    if ({resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty, resp_victim_tag} !== {4'b1011, 20'h12345}) begin
      n_err++;
      $display("FAIL victim_resp: v/hit/vv/vd=%b vtag=%h want 1011 12345",
               {resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty}, resp_victim_tag);
    end
    n_cmp++;
    if ({req_ready, ts_en} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_in_miss: rdy/en=%b want 00", {req_ready, ts_en});
    end
    next_cycle();
    flush = 1'b0;
    #7;
    n_cmp++;
    if ({req_ready, ts_en, resp_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL miss_held: rdy/en/rv=%b want 000", {req_ready, ts_en, resp_valid});
    end
    next_cycle();
    refill_valid = 1'b1;
    #7;
    n_cmp++;
    if ({ts_en, ts_we, ts_addr, ts_wdata} !== {2'b11, 8'd5, 22'h200001}) begin
      n_err++;
      $display("FAIL victim_refill: en/we=%b addr=%0d wdata=%h want 11 5 200001", {ts_en, ts_we}, ts_addr, ts_wdata);
    end
    next_cycle();
    refill_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_index = 8'd5; req_tag = 20'h00001; req_we = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      #7;
      n_cmp++;
      if ({resp_valid, resp_hit, req_ready} !== 3'b111) begin
        n_err++;
        $display("FAIL b2b_hit %0d: rv/hit/rdy=%b want 111", i, {resp_valid, resp_hit, req_ready});
      end
      next_cycle();
    end
    req_valid = 1'b0;
    #7;
    n_cmp++;
    if ({resp_valid, resp_hit} !== 2'b11) begin
      n_err++;
      $display("FAIL b2b_last: rv/hit=%b want 11", {resp_valid, resp_hit});
    end
    next_cycle();
    #7;
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: rv=%b want 0", resp_valid);
    end
    next_cycle();
  endtask

  task automatic test_flush_priority();
    flush = 1'b1; req_valid = 1'b1; req_index = 8'd5; req_tag = 20'h00001;
    #7;
    n_cmp++;
    if ({req_ready, ts_en} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_prio: rdy/en=%b want 00", {req_ready, ts_en});
    end
    next_cycle();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_resp: rv=%b want 0", resp_valid);
    end
    #(-1 + 1);
    sweep_check("flush_sweep", 0);
  endtask

  task automatic test_reset_in_miss();
    req_valid = 1'b1; req_index = 8'd9; req_tag = 20'hABCDE; req_we = 1'b1;
    next_cycle();
    req_valid = 1'b0;
    #7;
    n_cmp++;
    if ({resp_valid, resp_hit, req_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL pre_reset_miss: rv/hit/rdy=%b want 100", {resp_valid, resp_hit, req_ready});
    end
    next_cycle();
    rst_n = 1'b0;
    #7;
    n_cmp++;
    if ({ts_en, ts_we, resp_valid, req_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_in_miss: en/we/rv/rdy=%b want 0000", {ts_en, ts_we, resp_valid, req_ready});
    end
    next_cycle();
    rst_n = 1'b1;
    refill_valid = 1'b1;
    #7;
    n_cmp++;
    if ({ts_en, ts_we, ts_addr, ts_wdata} !== {2'b11, 8'd0, 22'h0}) begin
      n_err++;
      $display("FAIL refill_after_reset: en/we=%b addr=%0d wdata=%h want 11 0 0", {ts_en, ts_we}, ts_addr, ts_wdata);
    end
    next_cycle();
    refill_valid = 1'b0;
    sweep_check("reset_sweep", 1);
    refill_valid = 1'b1;
    #7;
    n_cmp++;
    if ({ts_en, ts_we, req_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL refill_in_idle: en/we/rdy=%b want 001", {ts_en, ts_we, req_ready});
    end
    next_cycle();
    refill_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_miss_refill();
    test_store_dirty();
    test_victim_and_miss_flush();
    test_back_to_back();
    test_flush_priority();
    test_reset_in_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
